// File: rtl/logic_done_multi.sv
// Multi-latency operation sequencer: per-type/hit latency with a floor, done/pre_done pulses,
// overlap detection. Define LOGIC_DONE_MULTI_STATS_EN to build the completed-operation counters.
module logic_done_multi #(
   parameter int unsigned MIN_CYCLES     = 1,
   parameter int unsigned RD_HIT_CYCLES  = 2,
   parameter int unsigned RD_MISS_CYCLES = 3,
   parameter int unsigned WR_HIT_CYCLES  = 2,
   parameter int unsigned WR_MISS_CYCLES = 3,
   parameter int unsigned STAT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              re,
   input  logic              we,
   input  logic              hit,
   output logic              pre_done,
   output logic              done,
   output logic              busy,
   output logic              op_is_write,
   output logic              overlap_err,
   output logic [STAT_W-1:0] rd_hit_cnt,
   output logic [STAT_W-1:0] rd_miss_cnt,
   output logic [STAT_W-1:0] wr_hit_cnt,
   output logic [STAT_W-1:0] wr_miss_cnt
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned L_RH  = max2(RD_HIT_CYCLES, MIN_CYCLES);
   localparam int unsigned L_RM  = max2(RD_MISS_CYCLES, MIN_CYCLES);
   localparam int unsigned L_WH  = max2(WR_HIT_CYCLES, MIN_CYCLES);
   localparam int unsigned L_WM  = max2(WR_MISS_CYCLES, MIN_CYCLES);
   localparam int unsigned L_MAX = max2(max2(L_RH, L_RM), max2(L_WH, L_WM));
   localparam int unsigned CW    = $clog2(L_MAX + 1);
   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW-1:0] TWO = CW'(2);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] lat;
   logic          req;
   logic          accept;
   logic          pre_done_r;
   logic          pre_done_c;

   // Read wins when both requests are present.
   always_comb begin
      lat = CW'(L_WM);
      if (re)
         lat = hit ? CW'(L_RH) : CW'(L_RM);
      else if (hit)
         lat = CW'(L_WH);
   end

   assign req        = re | we;
   assign accept     = req && (state != WAIT);
   assign pre_done_c = rst && accept && (lat == ONE);
   assign pre_done   = pre_done_r | pre_done_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         pre_done_r  <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         op_is_write <= 1'b0;
         overlap_err <= 1'b0;
      end else begin
         done       <= 1'b0;
         pre_done_r <= 1'b0;
         if (accept) begin
            op_is_write <= we & ~re;
            if (re & we)
               overlap_err <= 1'b1;
            if (lat == ONE) begin
               state <= DONE;
               done  <= 1'b1;
               busy  <= 1'b0;
               cnt   <= '0;
            end else begin
               state      <= WAIT;
               busy       <= 1'b1;
               cnt        <= lat - ONE;
               pre_done_r <= (lat == TWO);
            end
         end else begin
            case (state)
               WAIT: begin
                  if (req)
                     overlap_err <= 1'b1;
                  cnt <= cnt - ONE;
                  if (cnt == ONE) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     pre_done_r <= (cnt == TWO);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef LOGIC_DONE_MULTI_STATS_EN
   logic op_hit;
   logic complete;
   logic fin_wr;
   logic fin_hit;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + STAT_W'(1);
   endfunction

   // An L=1 operation completes on its own accept edge, so its type comes from the live inputs.
   assign complete = (accept && (lat == ONE)) || ((state == WAIT) && (cnt == ONE));
   assign fin_wr   = accept ? (we & ~re) : op_is_write;
   assign fin_hit  = accept ? hit : op_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_hit      <= 1'b0;
         rd_hit_cnt  <= '0;
         rd_miss_cnt <= '0;
         wr_hit_cnt  <= '0;
         wr_miss_cnt <= '0;
      end else begin
         if (accept)
            op_hit <= hit;
         if (complete) begin
            case ({fin_wr, fin_hit})
               2'b01:   rd_hit_cnt  <= sat_inc(rd_hit_cnt);
               2'b00:   rd_miss_cnt <= sat_inc(rd_miss_cnt);
               2'b11:   wr_hit_cnt  <= sat_inc(wr_hit_cnt);
               default: wr_miss_cnt <= sat_inc(wr_miss_cnt);
            endcase
         end
      end
   end
`else
   assign rd_hit_cnt  = '0;
   assign rd_miss_cnt = '0;
   assign wr_hit_cnt  = '0;
   assign wr_miss_cnt = '0;
`endif

endmodule

// File: doc/logic_done_multi.md
LOGIC_DONE_MULTI -- requirements
Module: logic_done_multi

Interface
REQ-001 Parameter MIN_CYCLES, default 1: floor on every operation latency; SHALL be >= 1.
REQ-002 Parameter RD_HIT_CYCLES, default 2: read-hit latency in cycles; SHALL be >= 1.
REQ-003 Parameter RD_MISS_CYCLES, default 3: read-miss latency in cycles; SHALL be >= 1.
REQ-004 Parameter WR_HIT_CYCLES, default 2: write-hit latency in cycles; SHALL be >= 1.
REQ-005 Parameter WR_MISS_CYCLES, default 3: write-miss latency in cycles; SHALL be >= 1.
REQ-006 Parameter STAT_W, default 16: width of the statistics counters.
REQ-007 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-008 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-009 re  in  1  read request.
REQ-010 we  in  1  write request.
REQ-011 hit  in  1  hit/miss qualifier, sampled with re/we.
REQ-012 pre_done  out  1  high exactly one cycle before done.
REQ-013 done  out  1  single-cycle completion pulse.
REQ-014 busy  out  1  operation in flight, not yet done.
REQ-015 op_is_write  out  1  latched type of the current or last operation.
REQ-016 overlap_err  out  1  sticky flag: a request was dropped or was ambiguous.
REQ-017 rd_hit_cnt, rd_miss_cnt, wr_hit_cnt, wr_miss_cnt  out  STAT_W each  completed-operation counters.

Function
REQ-018 Effective latency: L = max(selected *_CYCLES, MIN_CYCLES). The selection is by the sampled re/we and hit.
REQ-019 The FSM SHALL have three states: IDLE, WAIT, DONE.
  - A request is accepted at a rising edge when the state is IDLE or DONE and (re | we) = 1.
REQ-020 Internal down-counter width: $clog2(max latency + 1).
  - Loaded with L-1 on accept; decrements once per cycle in WAIT.
REQ-021 Request accepted at edge E0 -> done = 1 in the cycle after edge E0+L-1, for exactly one cycle.
  - L = 1: done is high in the cycle immediately after accept.
REQ-022 pre_done SHALL be high in the cycle before done.
  - L >= 2: pre_done is registered and high when state = WAIT and counter = 1.
  - L = 1: pre_done is combinational: (re | we) & (state IDLE or DONE) & (selected latency = 1).
REQ-023 busy SHALL be 1 from the cycle after accept through the cycle before done, and 0 in the DONE cycle.
REQ-024 A request presented in the DONE cycle SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-025 A request presented while in WAIT SHALL be ignored: no effect on timing; overlap_err is set to 1.
REQ-026 re = 1 and we = 1 together on accept: the read SHALL be taken; overlap_err is set to 1.
REQ-027 op_is_write SHALL update only on accept and hold until the next accept.
REQ-028 overlap_err SHALL clear only on reset.
REQ-029 On the done edge, the counter matching the operation type and hit SHALL increment by 1.
  - Counters saturate at 2^STAT_W - 1.

Reset
REQ-030 rst = 0 SHALL immediately force: state IDLE; internal counter 0; pre_done 0; done 0; busy 0; op_is_write 0; overlap_err 0; all statistics counters 0.
REQ-031 Reset mid-operation SHALL abandon the operation with no done pulse and no counter increment.
REQ-032 After rst returns to 1, the first rising edge SHALL be able to accept a request.

Configuration
REQ-033 Macro LOGIC_DONE_MULTI_STATS_EN defined: the four statistics counters SHALL be implemented as in REQ-029.
REQ-034 Macro LOGIC_DONE_MULTI_STATS_EN undefined: no counter logic; the four count ports remain and SHALL be tied to 0; all other behaviour is unchanged.

Verification
REQ-035 Defaults: re=1, hit=0 for one cycle, then idle -> pre_done 2 cycles after accept, done 3 cycles after accept, busy high 2 cycles; rd_miss_cnt=1.
REQ-036 MIN_CYCLES=4, we=1, hit=1 -> done 4 cycles after accept (floor applied); wr_hit_cnt=1; op_is_write=1.
REQ-037 All latencies =1: re=1, hit=1 held 3 cycles -> pre_done high combinationally in each request cycle; done high 3 consecutive cycles; busy stays 0; rd_hit_cnt=3.
REQ-038 Defaults: we=1, hit=0 accepted, then re=1 one cycle later (in WAIT) -> read ignored, single done at +3, overlap_err=1; a new request in the DONE cycle -> accepted.
REQ-039 re=1 and we=1 together -> read latency applied, op_is_write=0, overlap_err=1.
REQ-040 rst=0 two cycles after a read-miss accept -> all outputs 0 immediately; no done pulse; counters 0.
  - Rerun with the macro undefined -> all count ports 0 throughout.
